// File: rtl/ls_port_arbiter.sv
// Local-store port arbiter: DMA > LSU > IF with an IF starvation guard.
// Ports: *_req/_we/_addr in, *_gnt/_done out, ls_en/ls_we/ls_addr/ls_owner out.
module ls_port_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_gnt,
  output logic              dma_done,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  output logic              lsu_gnt,
  output logic              lsu_done,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic              ls_en,
  output logic              ls_we,
  output logic [ADDR_W-1:0] ls_addr,
  output logic [1:0]        ls_owner
);

  localparam int CNT_W = 4;
  localparam int SC_W  = 8;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_DMA  = 2'd1;
  localparam logic [1:0] OWN_LSU  = 2'd2;
  localparam logic [1:0] OWN_IF   = 2'd3;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [2:0]        done_q, done_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        win;
  logic              force_if;

  // Owner code to {dma, lsu, if} strobe vector.
  function automatic logic [2:0] sel(
    input logic [1:0] o
  );
    return {o == OWN_DMA, o == OWN_LSU, o == OWN_IF};
  endfunction

  assign force_if = if_req &&
    (starve_q == SC_W'(STARVE_MAX));

  always_comb begin
    win = OWN_NONE;
    priority case (1'b1)
      force_if: win = OWN_IF;
      dma_req:  win = OWN_DMA;
      lsu_req:  win = OWN_LSU;
      if_req:   win = OWN_IF;
      default:  win = OWN_NONE;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    gnt_d    = 3'b000;
    done_d   = 3'b000;
    en_d     = 1'b0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    owner_d  = owner_q;
    unique case (state_q)
      IDLE: begin
        addr_d  = '0;
        owner_d = OWN_NONE;
        if (!if_req || win == OWN_IF) begin
          starve_d = '0;
        end else if (!force_if) begin
          starve_d = starve_q + 1'b1;
        end
        if (win != OWN_NONE) begin
          gnt_d   = sel(win);
          en_d    = 1'b1;
          owner_d = win;
          cnt_d   = CNT_W'(LAT);
          state_d = BUSY;
          unique case (win)
            OWN_DMA: begin
              we_d   = dma_we;
              addr_d = dma_addr;
            end
            OWN_LSU: begin
              we_d   = lsu_we;
              addr_d = lsu_addr;
            end
            default: begin
              we_d   = 1'b0;
              addr_d = if_addr;
            end
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          done_d  = sel(owner_q);
          owner_d = OWN_NONE;
          addr_d  = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      starve_q <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      owner_q  <= OWN_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      owner_q  <= owner_d;
    end
  end

  assign dma_gnt  = gnt_q[2];
  assign lsu_gnt  = gnt_q[1];
  assign if_gnt   = gnt_q[0];
  assign dma_done = done_q[2];
  assign lsu_done = done_q[1];
  assign if_done  = done_q[0];
  assign ls_en    = en_q;
  assign ls_we    = we_q;
  assign ls_addr  = addr_q;
  assign ls_owner = owner_q;

endmodule

// File: tb/tb_ls_port_arbiter.sv
// Randomized scoreboard bench for ls_port_arbiter.
// Transaction-level model predicts grants; a negedge monitor checks them.
module tb_ls_port_arbiter;

  localparam int AW   = 11;
  localparam int LAT  = 2;
  localparam int SMAX = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic          dma_gnt, dma_done;
  logic          lsu_req, lsu_we;
  logic [AW-1:0] lsu_addr;
  logic          lsu_gnt, lsu_done;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_done;
  logic          ls_en, ls_we;
  logic [AW-1:0] ls_addr;
  logic [1:0]    ls_owner;

  always #5 clk = ~clk;

  ls_port_arbiter #(
    .ADDR_W(AW),
    .LAT(LAT),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .dma_req(dma_req),
    .dma_we(dma_we),
    .dma_addr(dma_addr),
    .dma_gnt(dma_gnt),
    .dma_done(dma_done),
    .lsu_req(lsu_req),
    .lsu_we(lsu_we),
    .lsu_addr(lsu_addr),
    .lsu_gnt(lsu_gnt),
    .lsu_done(lsu_done),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_gnt(if_gnt),
    .if_done(if_done),
    .ls_en(ls_en),
    .ls_we(ls_we),
    .ls_addr(ls_addr),
    .ls_owner(ls_owner)
  );

  typedef struct {
    int            g;
    logic [1:0]    own;
    logic          we;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t gq[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_n = 0;
  logic rst_s = 1'b1;

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    rst_s  <= reset;
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%0h required=%0h",
               nm, edge_n, act, exp);
    end
  endtask

  function automatic logic [2:0] ovec(logic [1:0] o);
    logic [2:0] v;
    v = 3'b000;
    if (o == 2'd1) v = 3'b100;
    if (o == 2'd2) v = 3'b010;
    if (o == 2'd3) v = 3'b001;
    return v;
  endfunction

  // requester and reference-model state
  bit            pend[3];
  logic          we_r[3];
  logic [AW-1:0] ad_r[3];
  int            rate[3];
  int            rst_rate = 0;
  int            starve = 0;
  int            free_e = 0;

  task automatic drive(bit frst);
    for (int r = 0; r < 3; r++) begin
      if (!pend[r] && $urandom_range(99) < rate[r]) begin
        pend[r] = 1'b1;
        we_r[r] = (r == 2) ? 1'b0 : 1'($urandom_range(1));
        ad_r[r] = AW'($urandom);
      end
    end
    dma_req  = pend[0];
    dma_we   = we_r[0];
    dma_addr = ad_r[0];
    lsu_req  = pend[1];
    lsu_we   = we_r[1];
    lsu_addr = ad_r[1];
    if_req   = pend[2];
    if_addr  = ad_r[2];
    reset = frst ||
      (rst_rate != 0 && $urandom_range(999) < rst_rate);
  endtask

  // One arbitration opportunity per free slot; IF is forced
  // once it has lost SMAX arbitrations in a row.
  task automatic model();
    int   k;
    int   w;
    exp_t e;
    k = edge_n + 1;
    if (reset) begin
      starve = 0;
      free_e = k + 1;
      return;
    end
    if (k < free_e) return;
    w = 0;
    if (if_req && starve == SMAX) w = 3;
    else if (dma_req) w = 1;
    else if (lsu_req) w = 2;
    else if (if_req) w = 3;
    if (!if_req || w == 3) starve = 0;
    else if (starve < SMAX) starve++;
    if (w != 0) begin
      e.g    = k;
      e.own  = 2'(w);
      e.we   = we_r[w-1];
      e.addr = ad_r[w-1];
      gq.push_back(e);
      pend[w-1] = 1'b0;
      free_e = k + LAT + 1;
    end
  endtask

  task automatic step(bit frst);
    @(negedge clk);
    drive(frst);
    @(posedge clk);
    model();
  endtask

  task automatic phase(int d, int l, int f,
                       int rr, int n);
    rate[0]  = d;
    rate[1]  = l;
    rate[2]  = f;
    rst_rate = rr;
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  initial begin
    reset = 1'b1;
    for (int r = 0; r < 3; r++) begin
      pend[r] = 1'b0;
      we_r[r] = 1'b0;
      ad_r[r] = '0;
      rate[r] = 0;
    end
    drive(1'b1);
    for (int i = 0; i < 3; i++) step(1'b1);
    phase(70, 70, 60, 0, 1500);
    phase(30, 50, 80, 8, 1500);
    phase(0, 0, 100, 0, 60);
    phase(90, 90, 40, 0, 1000);
    phase(0, 100, 100, 0, 200);
    phase(0, 0, 0, 0, 20);
    chk("queue_drained", gq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  // monitor
  initial begin
    bit         active;
    exp_t       act;
    exp_t       e;
    logic [2:0] gv;
    logic [2:0] dv;
    active = 1'b0;
    forever begin
      @(negedge clk);
      gv = {dma_gnt, lsu_gnt, if_gnt};
      dv = {dma_done, lsu_done, if_done};
      if (rst_s) begin
        chk("reset_zero",
            int'({gv, dv, ls_en, ls_we, ls_addr, ls_owner}),
            0);
        active = 1'b0;
        continue;
      end
      if (active && edge_n == act.g + LAT) begin
        chk("done_vec", int'(dv), int'(ovec(act.own)));
        chk("owner_clr", int'(ls_owner), 0);
        active = 1'b0;
      end else if (active) begin
        chk("done_early", int'(dv), 0);
        chk("owner_hold", int'(ls_owner), int'(act.own));
        chk("addr_hold", int'(ls_addr), int'(act.addr));
      end else if (gq.size() == 0 || gq[0].g != edge_n) begin
        chk("done_idle", int'(dv), 0);
        chk("owner_idle", int'(ls_owner), 0);
      end
      if (gq.size() > 0 && gq[0].g == edge_n) begin
        e = gq.pop_front();
        chk("gnt_vec", int'(gv), int'(ovec(e.own)));
        chk("gnt_en", int'(ls_en), 1);
        chk("gnt_we", int'(ls_we), int'(e.we));
        chk("gnt_addr", int'(ls_addr), int'(e.addr));
        chk("gnt_owner", int'(ls_owner), int'(e.own));
        chk("gnt_nodone", int'(dv), 0);
        active = 1'b1;
        act = e;
      end else begin
        chk("no_gnt", int'({gv, ls_en}), 0);
      end
    end
  end

endmodule

// File: doc/ls_port_arbiter.md
Name: ls_port_arbiter

Overview:
- Arbitrates the single SPU local-store port between three requesters: DMA, load/store unit (LSU) and instruction fetch (IF).
- Sits between the requesters and the local-store array, and drives the array's enable, write-enable and address.
- Fixed priority is DMA > LSU > IF. A starvation guard forces an IF grant after a bounded number of lost arbitrations, so the fetch path (16-instruction line reads) always makes progress.

Parameters:
- ADDR_W, 11, local-store quadword address width.
- LAT, 2, local-store access latency in cycles from ls_en to completion (legal range 1..15).
- STARVE_MAX, 8, number of consecutive lost IF arbitrations after which IF gets top priority (legal range 1..255).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- dma_req  in  1  DMA access request.
- dma_we  in  1  DMA write (1) or read (0).
- dma_addr  in  ADDR_W  DMA quadword address.
- dma_gnt  out  1  one-cycle grant pulse to DMA.
- dma_done  out  1  one-cycle completion pulse to DMA.
- lsu_req, lsu_we, lsu_addr, lsu_gnt, lsu_done: same widths and meanings as the DMA group, for the LSU.
- if_req  in  1  IF line-read request.
- if_addr  in  ADDR_W  IF line address.
- if_gnt  out  1  one-cycle grant pulse to IF.
- if_done  out  1  one-cycle completion pulse to IF.
- ls_en  out  1  local-store access strobe, one cycle long.
- ls_we  out  1  local-store write enable, valid with ls_en.
- ls_addr  out  ADDR_W  local-store address, valid with ls_en.
- ls_owner  out  2  owner of the current access: 0 = none, 1 = DMA, 2 = LSU, 3 = IF. Held for the whole access.

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- Reset values: all outputs 0. State is IDLE, the latency counter is 0 and starve_cnt is 0.
- Reset while BUSY: the access is abandoned and no done pulse is produced. On the cycle after reset is sampled, all outputs are 0.
- All outputs are registered.
- Requester contract:
  - Hold req, we and addr stable until gnt is seen.
  - Drop req in the cycle after gnt unless another access is wanted.
  - A req still high when the arbiter re-enters IDLE is treated as a new request.
- IDLE state, arbitrating on the current request inputs:
  - Winner: IF if if_req is high and starve_cnt == STARVE_MAX. Otherwise the first of DMA, LSU, IF with req high.
  - If there is a winner, at the next edge register gnt = 1 for the winner, ls_en = 1, ls_we = winner we (IF always reads, so 0), ls_addr = winner addr, and ls_owner = winner code. Load the latency counter with LAT and move to BUSY.
  - If there is no request, stay in IDLE with outputs 0.
- BUSY state:
  - gnt and ls_en are high only on the first BUSY cycle.
  - ls_owner and ls_addr are held until return to IDLE.
  - The counter decrements each cycle. When it reaches 1, at the next edge pulse the owner's done for one cycle, clear ls_owner and return to IDLE.
  - A grant cycle at t gives done at t + LAT.
  - The next grant is no earlier than t + LAT + 1, so throughput is one access per LAT + 1 cycles.
- Starvation counter (updated only on IDLE arbitration edges):
  - if_req high and IF loses: increment, saturating at STARVE_MAX.
  - IF wins, or if_req is low: clear to 0.
  - It also clears on reset.
- The forced-IF rule overrides DMA. This bounds the IF wait at STARVE_MAX + 1 accesses.
- Requests arriving during BUSY are ignored until IDLE.
- Simultaneous requests are resolved solely by the priority rules above.
- Exactly one of dma_gnt, lsu_gnt and if_gnt may be high in any cycle. The same holds for the done signals.

Test Plan:
- IF alone, LAT=2, if_req=1 and if_addr=0x010 sampled at cycle 2:
  - Cycle 3: if_gnt=1, ls_en=1, ls_we=0, ls_addr=0x010, ls_owner=3.
  - Cycle 5: if_done=1. Cycle 6: ls_owner=0.
- dma_req, lsu_req and if_req all asserted at cycle 2, each held until its grant, LAT=2:
  - Grants DMA at cycle 3, LSU at cycle 6, IF at cycle 9.
  - Done pulses at cycles 5, 8 and 11. No cycle has two grants.
- STARVE_MAX=3, LAT=1, lsu_req held high continuously, if_req high from cycle 2:
  - LSU wins three arbitrations.
  - The fourth arbitration grants IF with starve_cnt=3, after which starve_cnt=0.
- LSU write, lsu_we=1, lsu_addr=0x7FF:
  - ls_en=1, ls_we=1, ls_addr=0x7FF, lsu_gnt=1 at the grant cycle.
  - lsu_done LAT cycles later.
- reset=1 in the cycle after dma_gnt, LAT=3:
  - The next cycle has all outputs 0. No dma_done ever appears.
  - With dma_req still high after reset is released, a fresh grant follows.
- if_req held high continuously, LAT=2:
  - if_gnt pulses every 3 cycles (3, 6, 9, ...).
  - starve_cnt stays 0 and ls_addr tracks if_addr at each grant.
